// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and mode-register field definitions
// for the device-side responder model.
package sdram_pkg;

  // Commands are {cs_n, ras_n, cas_n, we_n}; cs_n=1 never matches any of these.
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_BT   = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  localparam int unsigned MODE_BL_LSB = 0;
  localparam int unsigned MODE_CL_LSB = 4;
  localparam int unsigned PRE_ALL_BIT = 10;

  localparam logic [2:0] BL_1    = 3'b000;
  localparam logic [2:0] BL_2    = 3'b001;
  localparam logic [2:0] BL_4    = 3'b010;
  localparam logic [2:0] BL_8    = 3'b011;
  localparam logic [2:0] BL_FULL = 3'b111;

  function automatic logic mode_legal(logic [2:0] bl, logic [2:0] cl);
    logic bl_ok;
    bl_ok = (bl == BL_1) || (bl == BL_2) || (bl == BL_4) || (bl == BL_8) || (bl == BL_FULL);
    return bl_ok && ((cl == 3'd2) || (cl == 3'd3));
  endfunction

endpackage

// File: rtl/sdram_dev_mem.sv
// Backing store for the SDRAM model: one write port with byte enables,
// one registered read port. Contents are never reset.
module sdram_dev_mem #(
  parameter int unsigned AddrW = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [1:0]       be_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [15:0]      wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i && be_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
    if (we_i && be_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
    if (re_i)            rdata_o              <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sdram_dev_model.sv
// SDRAM device responder: decodes controller commands, tracks banks and
// mode, stores write bursts and returns read bursts after CAS latency.
module sdram_dev_model
  import sdram_pkg::*;
#(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned ROW_W     = 12,
  parameter int unsigned COL_W     = 9,
  parameter int unsigned INIT_AREF = 2
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [1:0]  sdram_bank,
  input  logic [11:0] sdram_addr,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic [15:0] aref_cnt,
  output logic        proto_err
);

  localparam logic [15:0]      InitAref = 16'(INIT_AREF);
  localparam logic [COL_W-1:0] PageMask = '1;

  function automatic logic [MEM_AW-1:0] mem_idx(logic [1:0] bank, logic [ROW_W-1:0] row,
                                                logic [COL_W-1:0] col);
    return MEM_AW'({bank, row, col});
  endfunction

  logic [3:0] cmd;
  logic       is_act, is_rd, is_wr, is_bt, is_pre, is_aref, is_lmr;

  assign cmd     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign is_act  = (cmd == CMD_ACT);
  assign is_rd   = (cmd == CMD_RD);
  assign is_wr   = (cmd == CMD_WR);
  assign is_bt   = (cmd == CMD_BT);
  assign is_pre  = (cmd == CMD_PRE);
  assign is_aref = (cmd == CMD_AREF);
  assign is_lmr  = (cmd == CMD_LMR);

  logic [3:0]       open_q;
  logic [ROW_W-1:0] row_q [4];
  logic [2:0]       bl_q;
  logic             cl3_q;
  logic             init_done_q;
  logic [15:0]      aref_cnt_q;
  logic             proto_err_q;

  logic             burst_act_q, burst_rd_q, burst_full_q;
  logic [COL_W-1:0] burst_col_q, burst_left_q, burst_mask_q;
  logic [1:0]       burst_bank_q;
  logic [ROW_W-1:0] burst_row_q;

  logic             mem_vld_q, d1_vld_q, dq_oe_q;
  logic [15:0]      d1_data_q, dq_out_q, mem_rdata;

  logic [2:0]       lmr_bl, lmr_cl;
  logic             lmr_ok, bank_open, rd_ok, wr_ok, act_ok, pre_hit, stop;
  logic             gen, gen_rd, gen_wr, mem_we, err, out_vld;
  logic [COL_W-1:0] bl_mask, cmd_col, col_nxt, start_nxt;
  logic [15:0]      out_data;
  logic [MEM_AW-1:0] burst_idx, wr_idx;

  always_comb begin
    bl_mask = '0;
    case (bl_q)
      BL_2:    bl_mask = COL_W'(1);
      BL_4:    bl_mask = COL_W'(3);
      BL_8:    bl_mask = COL_W'(7);
      BL_FULL: bl_mask = PageMask;
      default: bl_mask = '0;
    endcase
  end

  assign lmr_bl    = sdram_addr[MODE_BL_LSB +: 3];
  assign lmr_cl    = sdram_addr[MODE_CL_LSB +: 3];
  assign lmr_ok    = mode_legal(lmr_bl, lmr_cl);
  assign bank_open = open_q[sdram_bank];
  assign rd_ok     = is_rd & init_done_q & bank_open;
  assign wr_ok     = is_wr & init_done_q & bank_open;
  assign act_ok    = is_act & init_done_q & ~bank_open;
  assign pre_hit   = is_pre & (sdram_addr[PRE_ALL_BIT] | (sdram_bank == burst_bank_q));

  // Any new column command or a terminate/precharge of the burst bank ends generation now.
  assign stop   = is_bt | is_rd | is_wr | pre_hit;
  assign gen    = burst_act_q & ~stop & ~srst;
  assign gen_rd = gen & burst_rd_q;
  assign gen_wr = gen & ~burst_rd_q;

  // Columns wrap inside the burst-aligned block; full page uses an all-ones mask.
  assign cmd_col   = sdram_addr[COL_W-1:0];
  assign col_nxt   = (burst_col_q & ~burst_mask_q) | ((burst_col_q + COL_W'(1)) & burst_mask_q);
  assign start_nxt = (cmd_col & ~bl_mask) | ((cmd_col + COL_W'(1)) & bl_mask);

  assign err = ((is_rd | is_wr | is_act) & ~init_done_q)
             | ((is_rd | is_wr) & init_done_q & ~bank_open)
             | (is_act & bank_open)
             | ((is_aref | is_lmr) & (|open_q))
             | (is_lmr & ~lmr_ok)
             | (is_lmr & lmr_ok & (aref_cnt_q < InitAref));

  assign burst_idx = mem_idx(burst_bank_q, burst_row_q, burst_col_q);
  assign wr_idx    = wr_ok ? mem_idx(sdram_bank, row_q[sdram_bank], cmd_col) : burst_idx;
  assign mem_we    = ~srst & (wr_ok | gen_wr);

  assign out_vld  = cl3_q ? d1_vld_q : mem_vld_q;
  assign out_data = cl3_q ? d1_data_q : mem_rdata;

  always_ff @(posedge sclk) begin
    if (srst) begin
      open_q       <= '0;
      bl_q         <= '0;
      cl3_q        <= 1'b0;
      init_done_q  <= 1'b0;
      aref_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
      burst_act_q  <= 1'b0;
      burst_rd_q   <= 1'b0;
      burst_full_q <= 1'b0;
      burst_col_q  <= '0;
      burst_left_q <= '0;
      burst_mask_q <= '0;
      burst_bank_q <= '0;
      burst_row_q  <= '0;
      mem_vld_q    <= 1'b0;
      d1_vld_q     <= 1'b0;
      d1_data_q    <= '0;
      dq_oe_q      <= 1'b0;
      dq_out_q     <= '0;
    end else begin
      proto_err_q <= proto_err_q | err;
      if (is_aref && (aref_cnt_q != 16'hFFFF)) aref_cnt_q <= aref_cnt_q + 16'd1;
      if (is_lmr && lmr_ok) begin
        bl_q  <= lmr_bl;
        cl3_q <= (lmr_cl == 3'd3);
        if (aref_cnt_q >= InitAref) init_done_q <= 1'b1;
      end

      if (act_ok) begin
        open_q[sdram_bank] <= 1'b1;
        row_q[sdram_bank]  <= sdram_addr[ROW_W-1:0];
      end
      if (is_pre) begin
        if (sdram_addr[PRE_ALL_BIT]) open_q <= '0;
        else                         open_q[sdram_bank] <= 1'b0;
      end

      // burst_left_q counts remaining generation steps after the current one.
      if (rd_ok || wr_ok) begin
        burst_rd_q   <= rd_ok;
        burst_full_q <= (bl_q == BL_FULL);
        burst_mask_q <= bl_mask;
        burst_bank_q <= sdram_bank;
        burst_row_q  <= row_q[sdram_bank];
        burst_act_q  <= rd_ok | (bl_mask != '0);
        burst_col_q  <= rd_ok ? cmd_col : start_nxt;
        burst_left_q <= rd_ok ? bl_mask : bl_mask - COL_W'(1);
      end else if (stop) begin
        burst_act_q <= 1'b0;
      end else if (gen) begin
        burst_col_q  <= col_nxt;
        burst_left_q <= burst_left_q - COL_W'(1);
        if (!burst_full_q && (burst_left_q == '0)) burst_act_q <= 1'b0;
      end

      // A WRITE flushes any read words still in flight.
      mem_vld_q <= gen_rd;
      d1_vld_q  <= mem_vld_q & ~is_wr;
      d1_data_q <= mem_rdata;
      dq_oe_q   <= out_vld & ~is_wr;
      dq_out_q  <= (out_vld & ~is_wr) ? out_data : '0;
    end
  end

  sdram_dev_mem #(
    .AddrW(MEM_AW)
  ) u_mem (
    .clk_i  (sclk),
    .we_i   (mem_we),
    .be_i   (~sdram_dqm),
    .waddr_i(wr_idx),
    .wdata_i(dq_in),
    .re_i   (gen_rd),
    .raddr_i(burst_idx),
    .rdata_o(mem_rdata)
  );

  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;
  assign init_done = init_done_q;
  assign aref_cnt  = aref_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sdram_dev_model.sv
// Directed self-checking bench for sdram_dev_model.
module tb_sdram_dev_model;

  localparam logic [3:0] C_DES  = 4'b1111;
  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_WR   = 4'b0100;
  localparam logic [3:0] C_BT   = 4'b0110;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LMR  = 4'b0000;

  logic        sclk = 1'b0;
  logic        srst;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  bank;
  logic [11:0] addr;
  logic [1:0]  dqm;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        init_done;
  logic [15:0] aref_cnt;
  logic        proto_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 sclk = ~sclk;

  sdram_dev_model dut (
    .sclk       (sclk),
    .srst       (srst),
    .sdram_cs_n (cs_n),
    .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n),
    .sdram_we_n (we_n),
    .sdram_bank (bank),
    .sdram_addr (addr),
    .sdram_dqm  (dqm),
    .dq_in      (dq_in),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .init_done  (init_done),
    .aref_cnt   (aref_cnt),
    .proto_err  (proto_err)
  );

  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    bank = b;
    addr = a;
  endtask

  // Advance past one rising edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    drive(C_DES, 2'd0, 12'd0);
    dqm = 2'b00;
    dq_in = 16'h0;
    tick();
    tick();
    vec_cnt++; if (dq_oe !== 1'b0) begin err_cnt++; $display("FAIL reset_dq_oe got %b want 0", dq_oe); end
    vec_cnt++; if (dq_out !== 16'h0) begin err_cnt++; $display("FAIL reset_dq_out got %h want 0000", dq_out); end
    vec_cnt++; if (init_done !== 1'b0) begin err_cnt++; $display("FAIL reset_init_done got %b want 0", init_done); end
    vec_cnt++; if (aref_cnt !== 16'h0) begin err_cnt++; $display("FAIL reset_aref_cnt got %h want 0000", aref_cnt); end
    vec_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
    srst = 1'b0;
    tick();
  endtask

  task automatic test_init();
    drive(C_NOP, 2'd0, 12'd0); tick();
    drive(C_AREF, 2'd0, 12'd0); tick();
    drive(C_AREF, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    vec_cnt++; if (aref_cnt !== 16'd2) begin err_cnt++; $display("FAIL init_aref_cnt got %0d want 2", aref_cnt); end
    vec_cnt++; if (init_done !== 1'b0) begin err_cnt++; $display("FAIL init_early got %b want 0", init_done); end
    drive(C_LMR, 2'd0, 12'h037); tick();
    drive(C_NOP, 2'd0, 12'd0);
    vec_cnt++; if (init_done !== 1'b1) begin err_cnt++; $display("FAIL init_done got %b want 1", init_done); end
    vec_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL init_proto_err got %b want 0", proto_err); end
  endtask

  task automatic test_bl4();
    logic exp_oe;
    drive(C_LMR, 2'd0, 12'h032); tick();
    drive(C_ACT, 2'd0, 12'd5); tick();
    drive(C_WR, 2'd0, 12'd0); dq_in = 16'h1000; tick();
    drive(C_NOP, 2'd0, 12'd0);
    for (int i = 1; i < 4; i++) begin
      dq_in = 16'h1000 + 16'(i);
      tick();
    end
    dq_in = 16'hDEAD; tick();
    drive(C_RD, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_oe = (k >= 3) && (k <= 6);
      vec_cnt++;
      if (dq_oe !== exp_oe) begin
        err_cnt++; $display("FAIL bl4_oe t+%0d got %b want %b", k, dq_oe, exp_oe);
      end
      if (exp_oe) begin
        vec_cnt++;
        if (dq_out !== 16'(16'h1000 + k - 3)) begin
          err_cnt++; $display("FAIL bl4_data t+%0d got %h want %h", k, dq_out, 16'(16'h1000 + k - 3));
        end
      end
    end
    vec_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL bl4_proto_err got %b want 0", proto_err); end
  endtask

  task automatic test_byte_mask();
    drive(C_WR, 2'd0, 12'd8); dq_in = 16'h1234; dqm = 2'b00; tick();
    drive(C_BT, 2'd0, 12'd0); dq_in = 16'h0000; tick();
    drive(C_WR, 2'd0, 12'd8); dq_in = 16'hFFFF; dqm = 2'b10; tick();
    drive(C_BT, 2'd0, 12'd0); dqm = 2'b00; tick();
    drive(C_RD, 2'd0, 12'd8); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick(); tick();
    vec_cnt++; if (dq_oe !== 1'b1) begin err_cnt++; $display("FAIL mask_oe got %b want 1", dq_oe); end
    vec_cnt++; if (dq_out !== 16'h12FF) begin err_cnt++; $display("FAIL mask_data got %h want 12ff", dq_out); end
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_full_page();
    drive(C_PRE, 2'd0, 12'h400); tick();
    drive(C_LMR, 2'd0, 12'h037); tick();
    drive(C_ACT, 2'd0, 12'd5); tick();
    drive(C_WR, 2'd0, 12'd511); dq_in = 16'hAAAA; tick();
    drive(C_NOP, 2'd0, 12'd0); dq_in = 16'hBBBB; tick();
    drive(C_BT, 2'd0, 12'd0); dq_in = 16'hDEAD; tick();
    drive(C_RD, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick(); tick();
    vec_cnt++; if (dq_oe !== 1'b1) begin err_cnt++; $display("FAIL fp_col0_oe got %b want 1", dq_oe); end
    vec_cnt++; if (dq_out !== 16'hBBBB) begin err_cnt++; $display("FAIL fp_col0_data got %h want bbbb", dq_out); end
    drive(C_BT, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    vec_cnt++; if (dq_out !== 16'h1001) begin err_cnt++; $display("FAIL fp_col1_data got %h want 1001", dq_out); end
    tick();
    vec_cnt++; if (dq_oe !== 1'b1) begin err_cnt++; $display("FAIL fp_drain_oe got %b want 1", dq_oe); end
    tick();
    vec_cnt++; if (dq_oe !== 1'b0) begin err_cnt++; $display("FAIL fp_stop_oe got %b want 0", dq_oe); end
    drive(C_RD, 2'd0, 12'd511); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick(); tick();
    vec_cnt++; if (dq_out !== 16'hAAAA) begin err_cnt++; $display("FAIL fp_col511_data got %h want aaaa", dq_out); end
    drive(C_BT, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    vec_cnt++; if (dq_out !== 16'hBBBB) begin err_cnt++; $display("FAIL fp_wrap_data got %h want bbbb", dq_out); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_write_interrupt();
    drive(C_RD, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick(); tick();
    vec_cnt++; if (dq_oe !== 1'b1) begin err_cnt++; $display("FAIL wint_pre_oe got %b want 1", dq_oe); end
    drive(C_WR, 2'd0, 12'd20); dq_in = 16'h5555; tick();
    drive(C_BT, 2'd0, 12'd0);
    vec_cnt++; if (dq_oe !== 1'b0) begin err_cnt++; $display("FAIL wint_oe got %b want 0", dq_oe); end
    tick();
    drive(C_NOP, 2'd0, 12'd0);
    vec_cnt++; if (dq_oe !== 1'b0) begin err_cnt++; $display("FAIL wint_oe2 got %b want 0", dq_oe); end
    vec_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL wint_proto_err got %b want 0", proto_err); end
    tick(); tick();
  endtask

  task automatic test_proto_err();
    drive(C_RD, 2'd1, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    vec_cnt++; if (proto_err !== 1'b1) begin err_cnt++; $display("FAIL perr_set got %b want 1", proto_err); end
    drive(C_RD, 2'd0, 12'd20); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick(); tick();
    vec_cnt++; if (dq_out !== 16'h5555) begin err_cnt++; $display("FAIL perr_rd_data got %h want 5555", dq_out); end
    drive(C_BT, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick();
    vec_cnt++; if (proto_err !== 1'b1) begin err_cnt++; $display("FAIL perr_sticky got %b want 1", proto_err); end
  endtask

  task automatic test_reset_mid_burst();
    drive(C_RD, 2'd0, 12'd0); tick();
    drive(C_NOP, 2'd0, 12'd0);
    tick(); tick(); tick();
    vec_cnt++; if (dq_oe !== 1'b1) begin err_cnt++; $display("FAIL rmb_pre_oe got %b want 1", dq_oe); end
    srst = 1'b1; tick();
    srst = 1'b0;
    vec_cnt++; if (dq_oe !== 1'b0) begin err_cnt++; $display("FAIL rmb_oe got %b want 0", dq_oe); end
    vec_cnt++; if (init_done !== 1'b0) begin err_cnt++; $display("FAIL rmb_init_done got %b want 0", init_done); end
    vec_cnt++; if (aref_cnt !== 16'h0) begin err_cnt++; $display("FAIL rmb_aref_cnt got %h want 0000", aref_cnt); end
    vec_cnt++; if (proto_err !== 1'b0) begin err_cnt++; $display("FAIL rmb_proto_err got %b want 0", proto_err); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      vec_cnt++;
      if (dq_oe !== 1'b0) begin err_cnt++; $display("FAIL rmb_abort_oe +%0d got %b want 0", k, dq_oe); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_bl4();
    test_byte_mask();
    test_full_page();
    test_write_interrupt();
    test_proto_err();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
